// File: rtl/lmc_clock_ctrl.sv
// lmc_clock_ctrl: run/stop/single-step controller for the LMC core clock.
// Divides clk into a one-cycle cpu_tick enable at one of four rates, gated by
// an IDLE/RUN/STEP/HALT machine driven by front-panel buttons and halt_in.
module lmc_clock_ctrl #(
  parameter int              CNT_W = 25,
  parameter logic [CNT_W-1:0] TC0  = CNT_W'(5_999_999),
  parameter logic [CNT_W-1:0] TC1  = CNT_W'(599_999),
  parameter logic [CNT_W-1:0] TC2  = CNT_W'(59_999),
  parameter logic [CNT_W-1:0] TC3  = CNT_W'(0)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_req,
  input  logic       stop_req,
  input  logic       step_req,
  input  logic       halt_in,
  input  logic [1:0] rate_sel,
  output logic       cpu_tick,
  output logic       running,
  output logic       halted,
  output logic       led
);

  typedef enum logic [1:0] {IDLE, RUN, STEP, HALT} state_e;

  // button bit order: {step, stop, run}
  logic [2:0]       s1_q, s2_q, prv_q, ev_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, tc_q, tc_sel;
  logic             tick_q, running_q, halted_q, led_q;

  logic ev_run, ev_stop, ev_step;
  assign ev_run  = ev_q[0];
  assign ev_stop = ev_q[1];
  assign ev_step = ev_q[2];

  // Two-flop synchroniser, previous-value flop and registered rising-edge event.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      prv_q <= '0;
      ev_q  <= '0;
    end else begin
      s1_q  <= {step_req, stop_req, run_req};
      s2_q  <= s1_q;
      prv_q <= s2_q;
      ev_q  <= s2_q & ~prv_q;
    end
  end

  // Terminal count for the currently selected rate.
  always_comb begin
    tc_sel = TC0;
    case (rate_sel)
      2'd0: tc_sel = TC0;
      2'd1: tc_sel = TC1;
      2'd2: tc_sel = TC2;
      2'd3: tc_sel = TC3;
      default: tc_sel = TC0;
    endcase
  end

  // Next state; halt beats stop beats step beats run.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ev_stop)     state_d = IDLE;
        else if (ev_step) state_d = STEP;
        else if (ev_run)  state_d = RUN;
      end
      RUN: begin
        if (halt_in)      state_d = HALT;
        else if (ev_stop) state_d = IDLE;
      end
      STEP:    state_d = IDLE;
      HALT:    if (ev_stop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, divider counter, TC latch and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tc_q      <= '0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
      led_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == RUN);
      halted_q  <= (state_d == HALT);
      led_q     <= led_q ^ tick_q;
      tick_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          // counter is cleared and rate latched on RUN entry
          if (state_d == RUN) begin
            cnt_q <= '0;
            tc_q  <= tc_sel;
          end
        end
        RUN: begin
          if (state_d != RUN) begin
            cnt_q <= '0;                 // leaving RUN: no tick, counter cleared
          end else if (cnt_q >= tc_q) begin
            tick_q <= 1'b1;
            cnt_q  <= '0;
            tc_q   <= tc_sel;            // new rate takes effect at the wrap
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        STEP:    tick_q <= 1'b1;         // committed even if stop arrives now
        default: ;
      endcase
    end
  end

  assign cpu_tick = tick_q;
  assign running  = running_q;
  assign halted   = halted_q;
  assign led      = led_q;

endmodule

// File: tb/tb_lmc_clock_ctrl.sv
// tb_lmc_clock_ctrl: directed plus randomized stimulus against a timeline
// reference model (absolute tick times, sample-history button events).
module tb_lmc_clock_ctrl;
  localparam int T0 = 9, T1 = 6, T2 = 4, T3 = 0;

  logic clk = 1'b0, rst = 1'b1;
  logic run_req = 0, stop_req = 0, step_req = 0, halt_in = 0;
  logic [1:0] rate_sel = 2'd0;
  logic cpu_tick, running, halted, led;

  lmc_clock_ctrl #(.CNT_W(8), .TC0(8'(T0)), .TC1(8'(T1)), .TC2(8'(T2)), .TC3(8'(T3))) dut (
    .clk(clk), .rst(rst), .run_req(run_req), .stop_req(stop_req), .step_req(step_req),
    .halt_in(halt_in), .rate_sel(rate_sel), .cpu_tick(cpu_tick), .running(running),
    .halted(halted), .led(led));

  always #5 clk = ~clk;

  int n_assert = 0, n_fail = 0;

  // reference model: mode 0 idle, 1 run, 2 step, 3 halt
  int t = 0, m_mode = 0, next_tick = 0;
  logic m_tick = 0, m_led = 0;
  logic [4:0] h_run = '0, h_stop = '0, h_step = '0;  // [k] = raw sample k edges ago

  function automatic int tc_of(input logic [1:0] r);
    case (r)
      2'd0: return T0;
      2'd1: return T1;
      2'd2: return T2;
      default: return T3;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic e_run, e_stop, e_step, nt;
    t++;
    if (rst) begin
      h_run = '0; h_stop = '0; h_step = '0;
      m_mode = 0; m_tick = 0; m_led = 0;
      return;
    end
    h_run  = {h_run[3:0],  run_req};
    h_stop = {h_stop[3:0], stop_req};
    h_step = {h_step[3:0], step_req};
    e_run  = h_run[3]  & ~h_run[4];
    e_stop = h_stop[3] & ~h_stop[4];
    e_step = h_step[3] & ~h_step[4];
    m_led = m_led ^ m_tick;
    nt = 0;
    case (m_mode)
      0: if (!e_stop) begin
           if (e_step) m_mode = 2;
           else if (e_run) begin m_mode = 1; next_tick = t + tc_of(rate_sel) + 1; end
         end
      1: if (halt_in) m_mode = 3;
         else if (e_stop) m_mode = 0;
         else if (t == next_tick) begin nt = 1; next_tick = t + tc_of(rate_sel) + 1; end
      2: begin nt = 1; m_mode = 0; end
      default: if (e_stop) m_mode = 0;
    endcase
    m_tick = nt;
  endtask

  task automatic tick_clk();
    @(posedge clk);
    model_edge();
    #1;
    chk("cpu_tick", 32'(cpu_tick), 32'(m_tick));
    chk("running",  32'(running),  32'(m_mode == 1));
    chk("halted",   32'(halted),   32'(m_mode == 3));
    chk("led",      32'(led),      32'(m_led));
  endtask

  task automatic run_n(input int n, output int ticks);
    ticks = 0;
    for (int i = 0; i < n; i++) begin tick_clk(); ticks += int'(cpu_tick); end
  endtask

  int tk;
  logic led_hold;

  initial begin
    // reset, then idle 100 cycles
    repeat (3) tick_clk();
    rst = 0;
    run_n(100, tk);
    chk("idle_ticks", tk, 0);

    // rate 2 (TC=4): RUN 3 edges after pulse, ticks 5,10,15.. edges after that
    rate_sel = 2'd2; run_req = 1; tick_clk(); run_req = 0;
    run_n(29, tk);
    chk("rate2_ticks", tk, 5);
    chk("rate2_led", 32'(led), 32'(1));
    stop_req = 1; tick_clk(); stop_req = 0;
    run_n(6, tk);
    chk("stop_cnt", 32'(dut.cnt_q), 0);

    // rate 3: tick every cycle in RUN, then stop holds led and clears counter
    rate_sel = 2'd3; run_req = 1; tick_clk(); run_req = 0;
    run_n(23, tk);
    chk("rate3_ticks", tk, 20);
    stop_req = 1; tick_clk(); stop_req = 0;
    run_n(4, tk);
    led_hold = led;
    run_n(10, tk);
    chk("rate3_after_stop", tk, 0);
    chk("rate3_led_hold", 32'(led), 32'(led_hold));
    chk("rate3_cnt", 32'(dut.cnt_q), 0);

    // held step button: exactly one tick
    step_req = 1; run_n(50, tk); step_req = 0;
    chk("step_held_ticks", tk, 1);
    run_n(5, tk);
    chk("step_idle", 32'(running | halted), 0);

    // halt in RUN, run ignored, stop acknowledges
    rate_sel = 2'd1; run_req = 1; tick_clk(); run_req = 0;
    run_n(12, tk);
    halt_in = 1; tick_clk(); halt_in = 0;
    chk("halt_flag", 32'(halted), 1);
    run_req = 1; tick_clk(); run_req = 0;
    run_n(15, tk);
    chk("halt_no_ticks", tk, 0);
    chk("halt_stays", 32'(halted), 1);
    stop_req = 1; tick_clk(); stop_req = 0;
    run_n(5, tk);
    chk("halt_ack", 32'(halted), 0);

    // run and stop on the same edge from RUN: stop wins
    rate_sel = 2'd0; run_req = 1; tick_clk(); run_req = 0;
    run_n(8, tk);
    run_req = 1; stop_req = 1; tick_clk(); run_req = 0; stop_req = 0;
    run_n(5, tk);
    chk("run_stop_same", 32'(running), 0);

    // reset mid-period in RUN
    rate_sel = 2'd3; run_req = 1; tick_clk(); run_req = 0;
    run_n(6, tk);
    rst = 1; tick_clk(); rst = 0;
    chk("rst_outs", 32'({cpu_tick, running, halted, led}), 0);
    run_n(5, tk);

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(11) == 0) run_req  = ~run_req;
      if ($urandom_range(11) == 0) stop_req = ~stop_req;
      if ($urandom_range(11) == 0) step_req = ~step_req;
      if ($urandom_range(39) == 0) halt_in  = ~halt_in;
      if ($urandom_range(29) == 0) rate_sel = 2'($urandom_range(3));
      rst = ($urandom_range(399) == 0);
      tick_clk();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/lmc_clock_ctrl.md
# lmc_clock_ctrl

Run/stop/single-step controller for the LMC core clock. Divides the board clock into a one-cycle `cpu_tick` enable at one of four selectable rates, gates it through a RUN/STOP/STEP/HALT state machine driven by debounced front-panel buttons and the CPU halt flag, and drives a heartbeat LED that toggles on every executed tick. It sits between the on-chip oscillator and the LMC core, replacing the free-running blink divider.

## Interface
Parameters:
- `CNT_W`, 25: divider counter width.
- `TC0`, 5_999_999: terminal count for `rate_sel`=0 (slowest).
- `TC1`, 599_999: terminal count for `rate_sel`=1.
- `TC2`, 59_999: terminal count for `rate_sel`=2.
- `TC3`, 0: terminal count for `rate_sel`=3 (tick every cycle).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `run_req` in 1: raw asynchronous run button, active high.
- `stop_req` in 1: raw asynchronous stop button, active high.
- `step_req` in 1: raw asynchronous single-step button, active high.
- `halt_in` in 1: CPU halt flag, synchronous to `clk`, level.
- `rate_sel` in 2: tick rate select.
- `cpu_tick` out 1: one-cycle CPU enable pulse, registered.
- `running` out 1: high while in RUN.
- `halted` out 1: high while in HALT.
- `led` out 1: heartbeat, toggles per `cpu_tick`.

## Operation
- Each button input passes through a 2-flop synchroniser plus a previous-value flop; event = sync rising edge, one cycle wide. Held buttons produce one event only.
- Event priority on the same edge: `halt_in` (RUN only) > stop > step > run.
- States: IDLE, RUN, STEP, HALT. Reset → IDLE.
- IDLE: run event → RUN; step event → STEP; `halt_in` ignored.
- RUN: counter increments each cycle; when counter == latched TC, `cpu_tick` pulses next cycle and counter returns to 0. Stop event → IDLE, counter cleared, no tick issued even if counter == TC on that edge. `halt_in` high → HALT, no tick issued that edge.
- STEP: issues exactly one `cpu_tick`, then → IDLE. Stop on the STEP edge still allows that tick (tick already committed); run/step events during STEP are discarded.
- HALT: run and step events ignored; stop event → IDLE (operator acknowledge).
- TC latch: `rate_sel` decoded and latched on RUN entry and at every counter wrap; changes mid-period take effect at the next wrap. Counter never exceeds latched TC (no wrap-around through 2^CNT_W).
- `led` toggles on each cycle `cpu_tick` is high; holds value in IDLE/HALT.
- `running`/`halted` registered, equal to state == RUN / HALT.

## Timing
- Reset values: `cpu_tick`=0, `running`=0, `halted`=0, `led`=0, counter=0, state IDLE, all sync flops 0.
- Button latency: raw input first sampled high at edge N → state transition at edge N+3.
- RUN entry at edge E clears counter; first `cpu_tick` high in the cycle after edge E+TC+1; subsequent ticks every TC+1 cycles. TC3=0 gives `cpu_tick` continuously high in RUN from E+1.
- STEP entry at edge E → `cpu_tick` high for exactly the cycle after edge E+1; state IDLE at edge E+1.
- `halt_in` sampled at edge H in RUN → HALT and `halted`=1 after edge H; no `cpu_tick` after edge H.
- `running`/`halted` update on the same edge as the state.
- `rst` mid-operation: all outputs to reset values at the next edge; a tick pending at that edge is dropped.

## Test plan
- Reset then idle 100 cycles, no buttons → `cpu_tick`, `running`, `halted`, `led` all 0.
- TC2 overridden to 4, `rate_sel`=2, pulse `run_req` at edge 10 → RUN at edge 13, ticks after edges 18, 23, 28…; `led` toggles each tick.
- `rate_sel`=3, run, then `stop_req` → `cpu_tick` high every cycle until stop transition edge, 0 after; counter 0; `led` holds.
- From IDLE hold `step_req` high 50 cycles → exactly one `cpu_tick`, state back to IDLE.
- In RUN, assert `halt_in` → `halted`=1, no further ticks; pulse `run_req` → no change; pulse `stop_req` → IDLE, `halted`=0.
- `run_req` and `stop_req` rise on the same edge from RUN → goes to IDLE; assert `rst` mid-period in RUN → all outputs 0 next edge, no tick.
